// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared mode encoding and limits for the universal shift register
package shift_reg_pkg;
  typedef enum logic [1:0] {MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD} shift_mode_t;
  localparam int MIN_DATA_WIDTH = 2;
endpackage

// File: rtl/shift_frame_counter.sv
// shift_frame_counter: counts shifts modulo DATA_WIDTH and pulses once per completed frame
module shift_frame_counter #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                 fastClk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrapPulse
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  logic wrap;
  assign wrap = inc && !clr && count == LAST;
  always_ff @(posedge fastClk) begin
    if (reset) begin
      count <= '0;
      wrapPulse <= 1'b0;
    end else begin
      wrapPulse <= wrap;
      count <= (clr || wrap) ? '0 : inc ? count + 1'b1 : count;
    end
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift-left/shift-right/load register with serial taps and frame pulse
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  fastClk,
  input  logic                  reset,
  input  logic                  shiftEn,
  input  logic [1:0]            mode,
  input  logic                  serInLsb,
  input  logic                  serInMsb,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  serOutMsb,
  output logic                  serOutLsb,
  output logic [CNT_WIDTH-1:0]  bitCount,
  output logic                  frameDone
);
  if (DATA_WIDTH < MIN_DATA_WIDTH) begin : g_bad_width
    $error("univ_shift_reg: DATA_WIDTH must be >= %0d", MIN_DATA_WIDTH);
  end
  logic [DATA_WIDTH-1:0] data_next;
  logic shl, shr, load;
  assign shl  = shiftEn && mode == MODE_SHL;
  assign shr  = shiftEn && mode == MODE_SHR;
  assign load = shiftEn && mode == MODE_LOAD;
  always_comb begin
    data_next = shl  ? {dataOut[DATA_WIDTH-2:0], serInLsb} :
                shr  ? {serInMsb, dataOut[DATA_WIDTH-1:1]} :
                load ? loadData : dataOut;
  end
  always_ff @(posedge fastClk) begin
    if (reset) dataOut <= '0;
    else dataOut <= data_next;
  end
  assign serOutMsb = dataOut[DATA_WIDTH-1];
  assign serOutLsb = dataOut[0];
  shift_frame_counter #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .fastClk  (fastClk),
    .reset    (reset),
    .inc      (shl || shr),
    .clr      (load),
    .count    (bitCount),
    .wrapPulse(frameDone)
  );
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vector table plus randomized run against an arithmetic model
module tb_univ_shift_reg;
  import shift_reg_pkg::*;
  localparam int W = 4;
  localparam int CW = $clog2(W);
  logic fastClk = 0, reset, shiftEn, serInLsb, serInMsb, serOutMsb, serOutLsb, frameDone;
  logic [1:0] mode;
  logic [W-1:0] loadData, dataOut;
  logic [CW-1:0] bitCount;
  int checks = 0, failures = 0;
  typedef struct {
    logic rst, en;
    logic [1:0] md;
    logic sl, sm;
    logic [W-1:0] ld, exp_d;
    int exp_c;
    logic exp_f;
  } vec_t;
  vec_t vq[$];
  int m_d, m_c, m_shifts;
  logic m_f;

  univ_shift_reg #(.DATA_WIDTH(W)) dut (
    .fastClk(fastClk), .reset(reset), .shiftEn(shiftEn), .mode(mode),
    .serInLsb(serInLsb), .serInMsb(serInMsb), .loadData(loadData),
    .dataOut(dataOut), .serOutMsb(serOutMsb), .serOutLsb(serOutLsb),
    .bitCount(bitCount), .frameDone(frameDone)
  );

  always #5 fastClk = ~fastClk;

  function automatic vec_t v(logic rst, logic en, logic [1:0] md, logic sl, logic sm,
                             logic [W-1:0] ld, logic [W-1:0] d, int c, logic f);
    vec_t r;
    r.rst = rst; r.en = en; r.md = md; r.sl = sl; r.sm = sm; r.ld = ld;
    r.exp_d = d; r.exp_c = c; r.exp_f = f;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst, logic en, logic [1:0] md, logic sl, logic sm, logic [W-1:0] ld);
    reset = rst; shiftEn = en; mode = md; serInLsb = sl; serInMsb = sm; loadData = ld;
    @(posedge fastClk);
    #1;
  endtask

  task automatic check_all(string tag, logic [W-1:0] d, int c, logic f);
    chk({tag, ".dataOut"}, 64'(dataOut), 64'(d));
    chk({tag, ".bitCount"}, 64'(bitCount), 64'(c));
    chk({tag, ".frameDone"}, 64'(frameDone), 64'(f));
    chk({tag, ".serOutMsb"}, 64'(serOutMsb), 64'(d[W-1]));
    chk({tag, ".serOutLsb"}, 64'(serOutLsb), 64'(d[0]));
  endtask

  // Reference model: register as an integer, frame tracked as a running shift total.
  task automatic model_step(logic rst, logic en, logic [1:0] md, logic sl, logic sm, logic [W-1:0] ld);
    m_f = 0;
    if (rst) begin
      m_d = 0; m_shifts = 0;
    end else if (en && md == MODE_SHL) begin
      m_d = (m_d * 2 + int'(sl)) % (1 << W); m_shifts++;
      m_f = (m_shifts % W == 0);
    end else if (en && md == MODE_SHR) begin
      m_d = m_d / 2 + int'(sm) * (1 << (W - 1)); m_shifts++;
      m_f = (m_shifts % W == 0);
    end else if (en && md == MODE_LOAD) begin
      m_d = int'(ld); m_shifts = 0;
    end
    m_c = m_shifts % W;
  endtask

  initial begin
    // plan 1: reset with busy inputs, then release
    vq.push_back(v(1, 1, MODE_LOAD, 1, 1, 4'hF, 4'h0, 0, 0));
    vq.push_back(v(1, 1, MODE_SHL,  1, 1, 4'h7, 4'h0, 0, 0));
    vq.push_back(v(0, 0, MODE_SHL,  1, 1, 4'h7, 4'h0, 0, 0));
    // plan 2
    vq.push_back(v(0, 1, MODE_SHL, 1, 0, 4'h0, 4'h1, 1, 0));
    vq.push_back(v(0, 1, MODE_SHL, 0, 0, 4'h0, 4'h2, 2, 0));
    vq.push_back(v(0, 1, MODE_SHL, 1, 0, 4'h0, 4'h5, 3, 0));
    vq.push_back(v(0, 1, MODE_SHL, 1, 0, 4'h0, 4'hB, 0, 1));
    vq.push_back(v(0, 1, MODE_HOLD, 0, 0, 4'h0, 4'hB, 0, 0));
    // plan 3
    vq.push_back(v(0, 1, MODE_LOAD, 0, 0, 4'hA, 4'hA, 0, 0));
    vq.push_back(v(0, 1, MODE_SHR,  0, 1, 4'h0, 4'hD, 1, 0));
    vq.push_back(v(0, 1, MODE_SHR,  0, 0, 4'h0, 4'h6, 2, 0));
    // plan 4: direction change and enable-low hold across every mode
    vq.push_back(v(0, 1, MODE_LOAD, 0, 0, 4'h3, 4'h3, 0, 0));
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'h7, 1, 0));
    vq.push_back(v(0, 1, MODE_SHL,  0, 0, 4'h0, 4'hE, 2, 0));
    vq.push_back(v(0, 0, MODE_SHL,  1, 1, 4'h9, 4'hE, 2, 0));
    vq.push_back(v(0, 0, MODE_SHR,  1, 1, 4'h9, 4'hE, 2, 0));
    vq.push_back(v(0, 0, MODE_LOAD, 1, 1, 4'h9, 4'hE, 2, 0));
    vq.push_back(v(0, 1, MODE_SHR,  0, 1, 4'h0, 4'hF, 3, 0));
    vq.push_back(v(0, 1, MODE_SHR,  0, 0, 4'h0, 4'h7, 0, 1));
    vq.push_back(v(0, 1, MODE_HOLD, 0, 0, 4'h0, 4'h7, 0, 0));
    // plan 5: load mid-frame restarts the count
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'hF, 1, 0));
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'hF, 2, 0));
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'hF, 3, 0));
    vq.push_back(v(0, 1, MODE_LOAD, 0, 0, 4'h5, 4'h5, 0, 0));
    vq.push_back(v(0, 1, MODE_SHL,  0, 0, 4'h0, 4'hA, 1, 0));
    vq.push_back(v(0, 1, MODE_SHL,  0, 0, 4'h0, 4'h4, 2, 0));
    vq.push_back(v(0, 1, MODE_SHL,  0, 0, 4'h0, 4'h8, 3, 0));
    vq.push_back(v(0, 1, MODE_SHL,  0, 0, 4'h0, 4'h0, 0, 1));
    // plan 6: reset on the wrapping edge suppresses the pulse
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'h1, 1, 0));
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'h3, 2, 0));
    vq.push_back(v(0, 1, MODE_SHL,  1, 0, 4'h0, 4'h7, 3, 0));
    vq.push_back(v(1, 1, MODE_SHL,  1, 0, 4'h0, 4'h0, 0, 0));
    vq.push_back(v(0, 0, MODE_HOLD, 0, 0, 4'h0, 4'h0, 0, 0));

    reset = 1; shiftEn = 0; mode = MODE_HOLD; serInLsb = 0; serInMsb = 0; loadData = '0;
    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].md, vq[i].sl, vq[i].sm, vq[i].ld);
      check_all($sformatf("vec%0d", i), vq[i].exp_d, vq[i].exp_c, vq[i].exp_f);
    end

    m_d = 0; m_shifts = 0;
    model_step(1, 0, MODE_HOLD, 0, 0, '0);
    drive(1, 0, MODE_HOLD, 0, 0, '0);
    for (int n = 0; n < 400; n++) begin
      logic rst, en, sl, sm;
      logic [1:0] md;
      logic [W-1:0] ld;
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 4) != 0);
      md  = ($urandom_range(0, 5) == 0) ? 2'(MODE_LOAD) : 2'($urandom_range(0, 2));
      sl  = 1'($urandom); sm = 1'($urandom); ld = W'($urandom);
      drive(rst, en, md, sl, sm, ld);
      model_step(rst, en, md, sl, sm, ld);
      check_all($sformatf("rnd%0d", n), W'(m_d), m_c, m_f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
